// File: rtl/stb_uinst_arb.sv
// Round-robin arbiter that shares one stb_shell micro-instruction port between N_REQ requesters.
// Issues one aligned instruction at a time as a single-cycle pulse and tracks it to completion.
module stb_uinst_arb #(
    parameter int unsigned N_REQ          = 4,
    parameter int unsigned ADDR_WIDTH     = 32,
    parameter int unsigned UR_ADDR_WIDTH  = 11,
    parameter int unsigned TIMEOUT_CYCLES = 4096,
    localparam int unsigned PW            = 16 + ADDR_WIDTH + UR_ADDR_WIDTH,
    localparam int unsigned IDW           = (N_REQ > 1) ? $clog2(N_REQ) : 1
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic [N_REQ-1:0]         i_req_valid,
    output logic [N_REQ-1:0]         o_req_ready,
    input  logic [N_REQ*PW-1:0]      i_req_payload,
    output logic                     o_micro_inst_u_valid,
    output logic [5:0]               o_micro_inst_u_smc_strb,
    output logic [3:0]               o_micro_inst_u_byte_strb,
    output logic [1:0]               o_micro_inst_u_brst,
    output logic [ADDR_WIDTH-1:0]    o_micro_inst_u_gr_base_addr,
    output logic [3:0]               o_micro_inst_u_ur_id,
    output logic [UR_ADDR_WIDTH-1:0] o_micro_inst_u_ur_addr,
    input  logic                     i_micro_inst_d_valid,
    input  logic                     i_micro_inst_d_done,
    output logic [N_REQ-1:0]         o_req_done,
    output logic [N_REQ-1:0]         o_req_err,
    output logic                     o_busy,
    output logic [IDW-1:0]           o_grant_id
);

    typedef enum logic [1:0] {StIdle, StIssue, StBusy, StDrain} state_e;

    localparam int unsigned    WDW      = $clog2(TIMEOUT_CYCLES) + 1;
    localparam logic [WDW-1:0] WdogLast = WDW'(TIMEOUT_CYCLES - 1);
    localparam int unsigned    IdOff    = UR_ADDR_WIDTH;
    localparam int unsigned    AddrOff  = UR_ADDR_WIDTH + 4;
    localparam int unsigned    BrstOff  = AddrOff + ADDR_WIDTH;
    localparam int unsigned    ByteOff  = BrstOff + 2;
    localparam int unsigned    SmcOff   = ByteOff + 4;

    state_e               state_q, state_d;
    logic [IDW-1:0]       rr_q, rr_d;
    logic [IDW-1:0]       grant_q, grant_d;
    logic [WDW-1:0]       wdog_q, wdog_d;
    logic [PW-1:0]        inst_q, inst_d;
    logic                 u_valid_q, u_valid_d;
    logic [N_REQ-1:0]     done_q, done_d;
    logic [N_REQ-1:0]     err_q, err_d;

    logic [PW-1:0]        pl_arr [N_REQ];
    logic                 found;
    logic [IDW-1:0]       gsel;
    logic [PW-1:0]        sel_pl;
    logic                 aligned;
    logic                 unused_d_valid;

    // Acceptance handshake is not needed for sequencing; completion alone drives the FSM.
    assign unused_d_valid = i_micro_inst_d_valid;

    for (genvar k = 0; k < N_REQ; k++) begin : g_pl
        assign pl_arr[k] = i_req_payload[k*PW +: PW];
    end

    function automatic logic [IDW-1:0] rot_idx(input logic [IDW-1:0] base,
                                               input int unsigned off);
        return IDW'((32'(base) + off) % N_REQ);
    endfunction

    // First valid requester at or after the rr pointer, wrapping.
    always_comb begin
        found = 1'b0;
        gsel  = '0;
        for (int unsigned i = 0; i < N_REQ; i++) begin
            if (!found && i_req_valid[rot_idx(rr_q, i)]) begin
                found = 1'b1;
                gsel  = rot_idx(rr_q, i);
            end
        end
    end

    assign sel_pl  = pl_arr[gsel];
    assign aligned = (sel_pl[AddrOff +: 4] == 4'h0);

    always_comb begin
        state_d     = state_q;
        rr_d        = rr_q;
        grant_d     = grant_q;
        wdog_d      = wdog_q;
        inst_d      = inst_q;
        u_valid_d   = 1'b0;
        done_d      = '0;
        err_d       = '0;
        o_req_ready = '0;
        case (state_q)
            StIdle: begin
                if (found) begin
                    o_req_ready[gsel] = 1'b1;
                    grant_d           = gsel;
                    rr_d              = (gsel == IDW'(N_REQ - 1)) ? '0 : gsel + 1'b1;
                    if (aligned) begin
                        inst_d    = sel_pl;
                        u_valid_d = 1'b1;
                        state_d   = StIssue;
                    end else begin
                        err_d[gsel] = 1'b1;
                    end
                end
            end
            StIssue: begin
                // Completion seen here is a protocol violation and is dropped.
                state_d = StBusy;
                wdog_d  = '0;
            end
            StBusy: begin
                if (i_micro_inst_d_done) begin
                    done_d[grant_q] = 1'b1;
                    state_d         = StIdle;
                end else if (wdog_q == WdogLast) begin
                    err_d[grant_q] = 1'b1;
                    state_d        = StDrain;
                end else begin
                    wdog_d = wdog_q + 1'b1;
                end
            end
            StDrain: begin
                if (i_micro_inst_d_done) begin
                    state_d = StIdle;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= StIdle;
            rr_q      <= '0;
            grant_q   <= '0;
            wdog_q    <= '0;
            inst_q    <= '0;
            u_valid_q <= 1'b0;
            done_q    <= '0;
            err_q     <= '0;
        end else begin
            state_q   <= state_d;
            rr_q      <= rr_d;
            grant_q   <= grant_d;
            wdog_q    <= wdog_d;
            inst_q    <= inst_d;
            u_valid_q <= u_valid_d;
            done_q    <= done_d;
            err_q     <= err_d;
        end
    end

    assign o_micro_inst_u_valid        = u_valid_q;
    assign o_micro_inst_u_ur_addr      = inst_q[0 +: UR_ADDR_WIDTH];
    assign o_micro_inst_u_ur_id        = inst_q[IdOff +: 4];
    assign o_micro_inst_u_gr_base_addr = inst_q[AddrOff +: ADDR_WIDTH];
    assign o_micro_inst_u_brst         = inst_q[BrstOff +: 2];
    assign o_micro_inst_u_byte_strb    = inst_q[ByteOff +: 4];
    assign o_micro_inst_u_smc_strb     = inst_q[SmcOff +: 6];
    assign o_req_done                  = done_q;
    assign o_req_err                   = err_q;
    assign o_busy                      = (state_q != StIdle);
    assign o_grant_id                  = grant_q;

endmodule

// File: doc/stb_uinst_arb.md
Name: stb_uinst_arb

Overview:
- Round-robin arbiter and sequencer that shares one stb_shell micro-instruction port between N_REQ requesters.
- Accepts one micro-instruction at a time and rejects misaligned base addresses.
- Issues the instruction as a one-cycle valid pulse, then holds it until the store buffer reports done.
- Returns per-requester done/error pulses; a watchdog guards against a hung store buffer.

Parameters:
N_REQ, 4, number of requesters (2..8)
ADDR_WIDTH, 32, global base address width
UR_ADDR_WIDTH, 11, user (UR) address width
TIMEOUT_CYCLES, 4096, max BUSY cycles before watchdog fires (>=4)
PW, 16+ADDR_WIDTH+UR_ADDR_WIDTH, payload width per requester (derived, localparam)

Ports:
clk  in  1  clock
rst_n  in  1  asynchronous, active-low reset
i_req_valid  in  N_REQ  per-requester instruction valid
o_req_ready  out  N_REQ  per-requester accept (combinational, one-hot)
i_req_payload  in  N_REQ*PW  requester k uses slice [k*PW +: PW]; field order LSB→MSB: ur_addr, ur_id[3:0], gr_base_addr, brst[1:0], byte_strb[3:0], smc_strb[5:0]
o_micro_inst_u_valid  out  1  one-cycle issue pulse to stb_shell
o_micro_inst_u_smc_strb  out  6  latched field
o_micro_inst_u_byte_strb  out  4  latched field
o_micro_inst_u_brst  out  2  latched field (00=1, 01=2, 10=4, 11=8 beats)
o_micro_inst_u_gr_base_addr  out  ADDR_WIDTH  latched field
o_micro_inst_u_ur_id  out  4  latched field
o_micro_inst_u_ur_addr  out  UR_ADDR_WIDTH  latched field
i_micro_inst_d_valid  in  1  stb acceptance indication; ignored for sequencing, present for interface compatibility
i_micro_inst_d_done  in  1  stb completion pulse
o_req_done  out  N_REQ  one-cycle completion pulse to the granted requester
o_req_err  out  N_REQ  one-cycle error pulse (misaligned address or timeout)
o_busy  out  1  high in every state except IDLE
o_grant_id  out  $clog2(N_REQ)  index of the current/last granted requester

Behaviour:
- Reset: all outputs 0; state IDLE; rr pointer 0; watchdog counter 0. Reset mid-operation drops the in-flight instruction silently, with no done or err pulse.
- States: IDLE, ISSUE, BUSY, DRAIN.
- Grant search (IDLE): scan i_req_valid starting at the rr pointer, wrapping modulo N_REQ. The first set bit wins (g).
  - o_req_ready[g]=1 in the same cycle; the transfer completes that cycle.
  - No ready is asserted outside IDLE.
- Accept at cycle t:
  - Payload of g is latched into the o_micro_inst_u_* registers.
  - o_grant_id becomes g at t+1.
  - rr pointer becomes (g+1) mod N_REQ.
- Alignment check at accept: gr_base_addr[3:0] != 0 rejects the instruction.
  - o_req_err[g]=1 at t+1.
  - u_* fields are not updated, u_valid stays 0, state stays IDLE.
  - The next grant may occur at t+1.
- Aligned accept: state moves to ISSUE at t+1.
  - o_micro_inst_u_valid=1 for exactly cycle t+1.
  - BUSY from t+2.
- u_* fields are held stable from issue until the next successful accept.
- BUSY:
  - The watchdog counts cycles.
  - On i_micro_inst_d_done at cycle d: o_req_done[g]=1 at d+1, state IDLE at d+1, and a new accept is allowed at d+1.
  - d_done during ISSUE is a protocol violation: ignored, with no done pulse.
- Watchdog: if TIMEOUT_CYCLES BUSY cycles elapse without d_done:
  - o_req_err[g]=1 on the next cycle.
  - State goes to DRAIN.
- DRAIN: wait for d_done, discard it (no done pulse), return to IDLE the following cycle. DRAIN has no timeout.
- Simultaneous d_done and watchdog expiry in the same cycle: done wins; no error is raised.
- o_req_done and o_req_err are never both asserted, and never for more than one requester.
- A requester may drop i_req_valid at any time before it is granted. There is no starvation: the worst-case wait is N_REQ-1 instructions ahead of it.

Test Plan:
- Single request: req0 valid, addr 0x1000, brst 2'b11 at t → ready0 at t; u_valid only at t+1 with addr 0x1000; d_done at t+10 → o_req_done=4'b0001 at t+11, o_busy 0 at t+11.
- Fairness: all four valid continuously, aligned addresses, d_done 5 cycles after each issue → grant order 0,1,2,3,0; each done pulse on the matching bit.
- Misaligned: req2 addr 0x0000_3004 → o_req_err=4'b0100 one cycle later; no u_valid pulse; u_* fields unchanged; next grant goes to req3 if valid.
- Timeout (TIMEOUT_CYCLES=16): issue with no d_done → o_req_err pulse 16 BUSY cycles later; o_busy stays 1 (DRAIN); a later d_done → no done pulse, IDLE the next cycle.
- Boundaries: d_done coincident with watchdog expiry → done only; reset asserted in BUSY → all outputs 0, pointer 0, next request from req1 with req0 also valid is granted to req0.
- Random: 1000 instructions with random strobes/brst/aligned addresses and random done delays (1..50) → every accepted instruction gets exactly one done; field values at issue match the scoreboard.
